// File: rtl/mpuf_eval_ctrl.sv
// Evaluation controller for the multi-PUF array: arms, settles and samples the cells
// VOTES times per challenge and returns a per-bit majority vote plus unanimity mask.

module mpuf_vote_lane #(
  parameter int VOTES = 5
) (
  input  logic clk,
  input  logic clr_n,
  input  logic clear,
  input  logic sample,
  input  logic last,
  input  logic bit_in,
  output logic data,
  output logic stable
);
  localparam int            VW   = $clog2(VOTES + 1);
  localparam logic [VW-1:0] HALF = VW'(VOTES / 2);

  logic [VW-1:0] ones;
  logic          seen0, seen1;
  logic [VW-1:0] ones_next;
  logic          seen0_next, seen1_next;

  // Include the in-flight sample so the final vote lands on the SAMPLE->DONE edge.
  assign ones_next  = ones + VW'(bit_in);
  assign seen0_next = seen0 | ~bit_in;
  assign seen1_next = seen1 | bit_in;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ones   <= '0;
      seen0  <= 1'b0;
      seen1  <= 1'b0;
      data   <= 1'b0;
      stable <= 1'b0;
    end else if (clear) begin
      ones  <= '0;
      seen0 <= 1'b0;
      seen1 <= 1'b0;
    end else if (sample) begin
      ones  <= ones_next;
      seen0 <= seen0_next;
      seen1 <= seen1_next;
      if (last) begin
        data   <= (ones_next > HALF);
        stable <= ~(seen0_next & seen1_next);
      end
    end
  end
endmodule

module mpuf_eval_ctrl #(
  parameter int N_CH    = 32,
  parameter int CW      = 32,
  parameter int ARM_CYC = 2,
  parameter int SETTLE  = 8,
  parameter int VOTES   = 5
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [CW-1:0]   req_chal,
  output logic [CW-1:0]   puf_chal,
  output logic            puf_clr,
  input  logic [N_CH-1:0] puf_resp,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [N_CH-1:0] resp_data,
  output logic [N_CH-1:0] resp_stable,
  output logic            busy
);
  localparam int             VW          = $clog2(VOTES + 1);
  localparam int             CMAX        = (ARM_CYC > SETTLE) ? ARM_CYC : SETTLE;
  localparam int             CCW         = $clog2(CMAX + 1);
  localparam logic [VW-1:0]  LAST_VOTE   = VW'(VOTES - 1);
  localparam logic [CCW-1:0] ARM_LAST    = CCW'(ARM_CYC - 1);
  localparam logic [CCW-1:0] SETTLE_LAST = CCW'(SETTLE - 1);

  if ((VOTES % 2) == 0 || VOTES < 1) begin : g_bad_votes
    $error("mpuf_eval_ctrl: VOTES must be odd and >= 1");
  end
  if (ARM_CYC < 1 || SETTLE < 1) begin : g_bad_timing
    $error("mpuf_eval_ctrl: ARM_CYC and SETTLE must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t         state;
  logic [CCW-1:0] cyc;
  logic [VW-1:0]  vote_idx;
  logic           start, sample, last;

  assign start  = (state == S_IDLE) && req_valid;
  assign sample = (state == S_SAMPLE);
  assign last   = (vote_idx == LAST_VOTE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= S_IDLE;
      cyc        <= '0;
      vote_idx   <= '0;
      puf_chal   <= '0;
      req_ready  <= 1'b1;
      puf_clr    <= 1'b1;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          puf_chal  <= req_chal;
          vote_idx  <= '0;
          cyc       <= '0;
          req_ready <= 1'b0;
          busy      <= 1'b1;
          state     <= S_ARM;
        end
        S_ARM: if (cyc == ARM_LAST) begin
          cyc     <= '0;
          puf_clr <= 1'b0;
          state   <= S_SETTLE;
        end else begin
          cyc <= cyc + 1'b1;
        end
        S_SETTLE: if (cyc == SETTLE_LAST) begin
          cyc   <= '0;
          state <= S_SAMPLE;
        end else begin
          cyc <= cyc + 1'b1;
        end
        S_SAMPLE: begin
          vote_idx <= vote_idx + 1'b1;
          puf_clr  <= 1'b1;
          if (last) begin
            resp_valid <= 1'b1;
            state      <= S_DONE;
          end else begin
            state <= S_ARM;
          end
        end
        // req_ready stays low here, so a concurrent request waits for IDLE.
        S_DONE: if (resp_ready) begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    mpuf_vote_lane #(.VOTES(VOTES)) u_lane (
      .clk    (clk),
      .clr_n  (clr_n),
      .clear  (start),
      .sample (sample),
      .last   (last),
      .bit_in (puf_resp[i]),
      .data   (resp_data[i]),
      .stable (resp_stable[i])
    );
  end
endmodule

// File: tb/tb_mpuf_eval_ctrl.sv
// Directed bench for mpuf_eval_ctrl: default instance plus a minimal-parameter instance.

module tb_mpuf_eval_ctrl;
  logic        clk = 1'b0;
  logic        clr_n;
  logic        req_valid, req_ready, puf_clr, resp_valid, resp_ready, busy;
  logic [31:0] req_chal, puf_chal, puf_resp, resp_data, resp_stable;

  logic        b_req_valid, b_req_ready, b_puf_clr, b_resp_valid, b_resp_ready, b_busy;
  logic [15:0] b_req_chal, b_puf_chal;
  logic [7:0]  b_puf_resp, b_resp_data, b_resp_stable;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mpuf_eval_ctrl dut (
    .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_chal(req_chal), .puf_chal(puf_chal), .puf_clr(puf_clr), .puf_resp(puf_resp),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_stable(resp_stable), .busy(busy)
  );

  mpuf_eval_ctrl #(.N_CH(8), .CW(16), .ARM_CYC(1), .SETTLE(1), .VOTES(1)) dut_b (
    .clk(clk), .clr_n(clr_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_chal(b_req_chal), .puf_chal(b_puf_chal), .puf_clr(b_puf_clr), .puf_resp(b_puf_resp),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_data(b_resp_data),
    .resp_stable(b_resp_stable), .busy(b_busy)
  );

  // Stimulus helpers: all start and end #1 after a rising edge.
  task automatic accept(input logic [31:0] c);
    req_chal  = c;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset_state();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++; if (puf_clr !== 1'b1) begin errors++; $display("FAIL rst_puf_clr got=%b exp=1", puf_clr); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (puf_chal !== 32'h0) begin errors++; $display("FAIL rst_puf_chal got=%h exp=0", puf_chal); end
    checks++; if (resp_stable !== 32'h0) begin errors++; $display("FAIL rst_resp_stable got=%h exp=0", resp_stable); end
  endtask

  task automatic test_nominal();
    int n;
    puf_resp = 32'h1234_5678;
    accept(32'hA5A5_0F0F);
    checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL nom_busy got busy=%b rdy=%b exp 1/0", busy, req_ready); end
    checks++; if (puf_chal !== 32'hA5A5_0F0F) begin errors++; $display("FAIL nom_puf_chal got=%h exp=a5a50f0f", puf_chal); end
    wait_valid(n);
    checks++; if (n !== 55) begin errors++; $display("FAIL nom_latency got=%0d exp=55", n); end
    checks++; if (resp_data !== 32'h1234_5678) begin errors++; $display("FAIL nom_resp_data got=%h exp=12345678", resp_data); end
    checks++; if (resp_stable !== 32'hFFFF_FFFF) begin errors++; $display("FAIL nom_resp_stable got=%h exp=ffffffff", resp_stable); end
    checks++; if (puf_clr !== 1'b1) begin errors++; $display("FAIL nom_done_clr got=%b exp=1", puf_clr); end
    finish_resp();
    checks++; if (resp_data !== 32'h1234_5678) begin errors++; $display("FAIL nom_idle_hold got=%h exp=12345678", resp_data); end
  endtask

  task automatic test_reset();
    puf_resp = 32'hFFFF_0000;
    accept(32'h0BAD_CAFE);
    repeat (4) @(posedge clk);
    #1 clr_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_req_ready got=%b exp=1", req_ready); end
    checks++; if (puf_clr !== 1'b1) begin errors++; $display("FAIL midrst_puf_clr got=%b exp=1", puf_clr); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL midrst_resp_data got=%h exp=0", resp_data); end
    checks++; if (puf_chal !== 32'h0) begin errors++; $display("FAIL midrst_puf_chal got=%h exp=0", puf_chal); end
    clr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_noisy();
    logic [31:0] v [5];
    v[0] = 32'h8000_0001; v[1] = 32'h8000_0000; v[2] = 32'h8000_0003;
    v[3] = 32'h8000_0001; v[4] = 32'h8000_0000;
    puf_resp = v[0];
    accept(32'h5555_AAAA);
    // Vote k is sampled on the edge 11*(k+1) after accept.
    for (int k = 0; k < 5; k++) begin
      puf_resp = v[k];
      repeat (11) @(posedge clk);
      #1;
    end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL noisy_valid got=%b exp=1", resp_valid); end
    checks++; if (resp_data !== 32'h8000_0001) begin errors++; $display("FAIL noisy_data got=%h exp=80000001", resp_data); end
    checks++; if (resp_stable !== 32'hFFFF_FFFC) begin errors++; $display("FAIL noisy_stable got=%h exp=fffffffc", resp_stable); end
    finish_resp();
  endtask

  task automatic test_backpressure();
    int n;
    puf_resp = 32'hDEAD_BEEF;
    accept(32'hC0DE_0001);
    resp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_early_ready got valid=%b busy=%b exp 0/1", resp_valid, busy); end
    resp_ready = 1'b0;
    wait_valid(n);
    checks++; if (n !== 50) begin errors++; $display("FAIL bp_latency got=%0d exp=50", n); end
    puf_resp = 32'h0000_0000;
    for (int i = 0; i < 10; i++) begin
      req_valid = i[0];
      req_chal  = 32'h7777_0000 + i;
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'hDEAD_BEEF || req_ready !== 1'b0 || puf_chal !== 32'hC0DE_0001) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got valid=%b data=%h rdy=%b chal=%h exp 1/deadbeef/0/c0de0001", i, resp_valid, resp_data, req_ready, puf_chal);
      end
    end
    req_valid = 1'b0;
    finish_resp();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got valid=%b rdy=%b exp 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_back_to_back();
    int n;
    puf_resp = 32'h0F0F_F0F0;
    accept(32'h1357_9BDF);
    wait_valid(n);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_chal   = 32'h2468_ACE0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || puf_chal !== 32'h1357_9BDF) begin
      errors++;
      $display("FAIL b2b_no_capture got valid=%b rdy=%b chal=%h exp 0/1/13579bdf", resp_valid, req_ready, puf_chal);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (puf_chal !== 32'h2468_ACE0 || busy !== 1'b1 || req_ready !== 1'b0 || puf_clr !== 1'b1) begin
      errors++;
      $display("FAIL b2b_capture got chal=%h busy=%b rdy=%b clr=%b exp 2468ace0/1/0/1", puf_chal, busy, req_ready, puf_clr);
    end
    puf_resp = 32'h00FF_00FF;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk); #1;
      checks++;
      if (puf_clr !== ((i < 2 || i == 11) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL b2b_clr_pattern cyc=%0d got=%b exp=%b", i, puf_clr, (i < 2 || i == 11));
      end
    end
    wait_valid(n);
    checks++; if (n !== 44) begin errors++; $display("FAIL b2b_latency got=%0d exp=44", n); end
    checks++; if (resp_data !== 32'h00FF_00FF) begin errors++; $display("FAIL b2b_data got=%h exp=00ff00ff", resp_data); end
    finish_resp();
  endtask

  task automatic test_sweep();
    int n;
    b_puf_resp  = 8'h5A;
    b_req_chal  = 16'hBEEF;
    b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    b_req_chal  = 16'h0000;
    n = 0;
    while (!b_resp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL sweep_latency got=%0d exp=3", n); end
    checks++; if (b_resp_data !== 8'h5A) begin errors++; $display("FAIL sweep_data got=%h exp=5a", b_resp_data); end
    checks++; if (b_resp_stable !== 8'hFF) begin errors++; $display("FAIL sweep_stable got=%h exp=ff", b_resp_stable); end
    checks++; if (b_puf_chal !== 16'hBEEF) begin errors++; $display("FAIL sweep_chal got=%h exp=beef", b_puf_chal); end
    b_resp_ready = 1'b1;
    @(posedge clk); #1;
    b_resp_ready = 1'b0;
    checks++; if (b_resp_valid !== 1'b0 || b_req_ready !== 1'b1) begin errors++; $display("FAIL sweep_release got valid=%b rdy=%b exp 0/1", b_resp_valid, b_req_ready); end
  endtask

  initial begin
    clr_n = 1'b0;
    req_valid = 1'b0; req_chal = '0; puf_resp = '0; resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_chal = '0; b_puf_resp = '0; b_resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset_state();
    clr_n = 1'b1;
    @(posedge clk); #1;
    test_nominal();
    test_reset();
    test_noisy();
    test_backpressure();
    test_back_to_back();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
